// File: rtl/fb_combiner_if.sv
// Bus bundle for fb_combiner: channel products, control strobes and DAC/overflow results.
// slave is the combiner side; master is whoever drives the feedback path.
interface fb_combiner_if #(
  parameter int NCH    = 4,
  parameter int IN_W   = 15,
  parameter int CORR_W = 13,
  parameter int OUT_W  = 13,
  parameter int SLEW_W = 8
);
  logic                       store_strb;
  logic                       out_cond;
  logic [NCH*IN_W-1:0]        ch_in;
  logic [NCH-1:0]             ch_en;
  logic [NCH-1:0]             ch_oflow;
  logic signed [CORR_W-1:0]   banana_corr;
  logic                       const_dac_en;
  logic signed [OUT_W-1:0]    const_dac;
  logic                       oflow_clr;
  logic [SLEW_W-1:0]          slew_max;
  logic signed [OUT_W-1:0]    fb_sgnl;
  logic                       fb_valid;
  logic                       oflow;
  logic                       oflow_sticky;
  logic [15:0]                sat_count;

  modport master (
    output store_strb, out_cond, ch_in, ch_en, ch_oflow, banana_corr,
           const_dac_en, const_dac, oflow_clr, slew_max,
    input  fb_sgnl, fb_valid, oflow, oflow_sticky, sat_count
  );

  modport slave (
    input  store_strb, out_cond, ch_in, ch_en, ch_oflow, banana_corr,
           const_dac_en, const_dac, oflow_clr, slew_max,
    output fb_sgnl, fb_valid, oflow, oflow_sticky, sat_count
  );
endinterface

// File: rtl/fb_combiner.sv
// Feedback combiner: masked channel sum plus banana correction through a registered adder tree,
// saturated to the DAC word. Define FB_SLEW_LIMIT_EN to ramp the output to zero when the store window closes.
module fb_combiner #(
  parameter int NCH    = 4,
  parameter int IN_W   = 15,
  parameter int CORR_W = 13,
  parameter int OUT_W  = 13,
  parameter int SLEW_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  fb_combiner_if.slave bus
);
  localparam int LVL   = $clog2(NCH + 1);
  localparam int NP    = 1 << LVL;
  localparam int SUM_W = ((IN_W > CORR_W) ? IN_W : CORR_W) + LVL;
  localparam int OMAX  = (1 << (OUT_W - 1)) - 1;
  localparam int OMIN  = -(1 << (OUT_W - 1));

`ifdef FB_SLEW_LIMIT_EN
  typedef enum logic [1:0] {IDLE, RUN, RAMP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  logic signed [SUM_W-1:0] leaf_d [NP];
  logic signed [SUM_W-1:0] tree [2*NP-1];
  logic [LVL:0]            cond_pipe;
  logic [LVL:0]            ofl_pipe;
  logic signed [OUT_W-1:0] sat_val_d, sat_val;
  logic                    sat_d, sat_flag, cond_s, ofl_s;
  state_t                  state, state_d;
  logic signed [OUT_W-1:0] fb_q, fb_d;
  logic                    valid_q, valid_d, oflow_q, oflow_d, sticky_q, sticky_d;
  logic [15:0]             count_q, count_d;
  logic                    sat_eff;

  // Tree leaves: masked channels, then the correction, then zero padding up to a power of two.
  for (genvar g = 0; g < NP; g++) begin : g_leaf
    if (g < NCH) begin : g_ch
      assign leaf_d[g] = bus.ch_en[g] ? SUM_W'($signed(bus.ch_in[g*IN_W +: IN_W])) : '0;
    end else if (g == NCH) begin : g_corr
      assign leaf_d[g] = SUM_W'(bus.banana_corr);
    end else begin : g_pad
      assign leaf_d[g] = '0;
    end
  end

  // Heap layout: node n has children 2n+1 and 2n+2, leaves sit at NP-1 and up, root is node 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) tree[NP-1+i] <= leaf_d[i];
    for (int n = 0; n < NP - 1; n++) tree[n] <= tree[2*n+1] + tree[2*n+2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_pipe <= '0;
      ofl_pipe  <= '0;
      cond_s    <= 1'b0;
    end else begin
      cond_pipe <= {cond_pipe[LVL-1:0], bus.out_cond};
      ofl_pipe  <= {ofl_pipe[LVL-1:0], |(bus.ch_oflow & bus.ch_en)};
      cond_s    <= cond_pipe[LVL];
    end
  end

  always_comb begin
    sat_d     = 1'b0;
    sat_val_d = OUT_W'(tree[0]);
    if (tree[0] > SUM_W'(OMAX)) begin
      sat_d     = 1'b1;
      sat_val_d = OUT_W'(OMAX);
    end else if (tree[0] < SUM_W'(OMIN)) begin
      sat_d     = 1'b1;
      sat_val_d = OUT_W'(OMIN);
    end
  end

  always_ff @(posedge clk) begin
    sat_val  <= sat_val_d;
    sat_flag <= sat_d;
    ofl_s    <= ofl_pipe[LVL];
  end

`ifdef FB_SLEW_LIMIT_EN
  int  ramp_cur, ramp_mag, ramp_step, ramp_move, ramp_next;
  logic ramp_done;

  always_comb begin
    ramp_cur  = int'(fb_q);
    ramp_mag  = (ramp_cur < 0) ? -ramp_cur : ramp_cur;
    ramp_step = (bus.slew_max == '0) ? 1 : int'(bus.slew_max);
    ramp_move = (ramp_mag < ramp_step) ? ramp_mag : ramp_step;
    ramp_next = (ramp_cur > 0) ? ramp_cur - ramp_move : ramp_cur + ramp_move;
    ramp_done = (ramp_mag <= ramp_step);
  end
`else
  logic unused_slew;
  assign unused_slew = ^bus.slew_max;
`endif

  always_comb begin
    state_d  = state;
    fb_d     = fb_q;
    valid_d  = 1'b0;
    oflow_d  = oflow_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    sat_eff  = sat_flag & ~bus.const_dac_en;
    if (bus.oflow_clr) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
    case (state)
      IDLE: begin
        fb_d = '0;
        if (bus.store_strb) state_d = RUN;
      end
      RUN: begin
        if (!bus.store_strb) begin
`ifdef FB_SLEW_LIMIT_EN
          state_d = RAMP;
`else
          state_d = IDLE;
          fb_d    = '0;
`endif
        end else if (cond_s) begin
          fb_d    = bus.const_dac_en ? bus.const_dac : sat_val;
          valid_d = 1'b1;
          oflow_d = sat_eff | ofl_s;
          // A set in the same cycle as a clear wins, so the count restarts at one.
          if (oflow_d) sticky_d = 1'b1;
          if (sat_eff && count_d != 16'hFFFF) count_d = count_d + 16'd1;
        end
      end
`ifdef FB_SLEW_LIMIT_EN
      RAMP: begin
        if (bus.store_strb) begin
          state_d = RUN;
        end else begin
          fb_d = OUT_W'(ramp_next);
          if (ramp_done) state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        fb_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fb_q     <= '0;
      valid_q  <= 1'b0;
      oflow_q  <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state    <= state_d;
      fb_q     <= fb_d;
      valid_q  <= valid_d;
      oflow_q  <= oflow_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign bus.fb_sgnl      = fb_q;
  assign bus.fb_valid     = valid_q;
  assign bus.oflow        = oflow_q;
  assign bus.oflow_sticky = sticky_q;
  assign bus.sat_count    = count_q;
endmodule

// File: tb/tb_fb_combiner.sv
// Directed bench for fb_combiner: vector table for sums, masks, saturation and flags,
// plus hand sequences for clear/set collision, back-to-back loads, store drop and reset flush.
module tb_fb_combiner;
  localparam int NCH = 4, IN_W = 15, CORR_W = 13, OUT_W = 13, SLEW_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_combiner_if #(.NCH(NCH), .IN_W(IN_W), .CORR_W(CORR_W), .OUT_W(OUT_W), .SLEW_W(SLEW_W)) bus();

  fb_combiner #(.NCH(NCH), .IN_W(IN_W), .CORR_W(CORR_W), .OUT_W(OUT_W), .SLEW_W(SLEW_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int c0, c1, c2, c3;
    logic [3:0] en;
    int corr;
    logic cen;
    int cdac;
    logic [3:0] cofl;
    logic clr;
    int e_fb;
    logic e_ofl;
    logic e_sticky;
    int e_cnt;
  } vec_t;

  vec_t vecs[14];
  vec_t v_load;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic driveChannels(input int c0, input int c1, input int c2, input int c3);
    bus.ch_in = {IN_W'(c3), IN_W'(c2), IN_W'(c1), IN_W'(c0)};
  endtask

  // Entered and left #1 after a rising edge; out_cond is sampled on the first edge inside.
  task automatic applyStimulus(input vec_t v, input int idx);
    int nvalid, lat, got_fb, got_ofl, got_st, got_cnt;
    if (v.clr) begin
      bus.oflow_clr = 1'b1;
      @(posedge clk); #1;
      bus.oflow_clr = 1'b0;
      checkOutput($sformatf("v%0d_clr_sticky", idx), int'(bus.oflow_sticky), 0);
      checkOutput($sformatf("v%0d_clr_count", idx), int'(bus.sat_count), 0);
    end
    driveChannels(v.c0, v.c1, v.c2, v.c3);
    bus.ch_en        = v.en;
    bus.banana_corr  = CORR_W'(v.corr);
    bus.const_dac_en = v.cen;
    bus.const_dac    = OUT_W'(v.cdac);
    bus.ch_oflow     = v.cofl;
    bus.out_cond     = 1'b1;
    @(posedge clk); #1;
    bus.out_cond = 1'b0;
    nvalid = 0; lat = -1; got_fb = 0; got_ofl = 0; got_st = 0; got_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.fb_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat     = k;
          got_fb  = int'(bus.fb_sgnl);
          got_ofl = int'(bus.oflow);
          got_st  = int'(bus.oflow_sticky);
          got_cnt = int'(bus.sat_count);
        end
      end
    end
    checkOutput($sformatf("v%0d_latency", idx), lat, 5);
    checkOutput($sformatf("v%0d_nvalid", idx), nvalid, 1);
    checkOutput($sformatf("v%0d_fb", idx), got_fb, v.e_fb);
    checkOutput($sformatf("v%0d_oflow", idx), got_ofl, int'(v.e_ofl));
    checkOutput($sformatf("v%0d_sticky", idx), got_st, int'(v.e_sticky));
    checkOutput($sformatf("v%0d_count", idx), got_cnt, v.e_cnt);
  endtask

  initial begin
    int nv, first;
    int vals[3];

    bus.store_strb = 1'b0; bus.out_cond = 1'b0; bus.ch_in = '0; bus.ch_en = '0;
    bus.ch_oflow = '0; bus.banana_corr = '0; bus.const_dac_en = 1'b0; bus.const_dac = '0;
    bus.oflow_clr = 1'b0; bus.slew_max = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset_fb", int'(bus.fb_sgnl), 0);
    checkOutput("reset_valid", int'(bus.fb_valid), 0);
    checkOutput("reset_oflow", int'(bus.oflow), 0);
    checkOutput("reset_sticky", int'(bus.oflow_sticky), 0);
    checkOutput("reset_count", int'(bus.sat_count), 0);

    //           c0     c1     c2     c3     en       corr  cen cdac  cofl     clr fb    ofl st cnt
    vecs[0]  = '{100,   200,   300,   400,   4'hF,    -50,  0,  0,    4'h0,    0,  950,  0, 0, 0};
    vecs[1]  = '{4000,  4000,  4000,  4000,  4'hF,    0,    0,  0,    4'h0,    0,  4095, 1, 1, 1};
    vecs[2]  = '{-4000, -4000, -4000, -4000, 4'hF,    0,    0,  0,    4'h0,    0,  -4096,1, 1, 2};
    vecs[3]  = '{10,    20,    30,    40,    4'b0101, 0,    0,  0,    4'h0,    1,  40,   0, 0, 0};
    vecs[4]  = '{4000,  4000,  4000,  4000,  4'hF,    0,    1,  1234, 4'h0,    0,  1234, 0, 0, 0};
    vecs[5]  = '{4000,  4000,  4000,  4000,  4'hF,    0,    1,  -7,   4'b1000, 0,  -7,   1, 1, 0};
    vecs[6]  = '{1,     1,     1,     1,     4'hF,    0,    0,  0,    4'b0010, 1,  4,    1, 1, 0};
    vecs[7]  = '{1,     1,     1,     1,     4'b1101, 0,    0,  0,    4'b0010, 1,  3,    0, 0, 0};
    vecs[8]  = '{4095,  0,     0,     0,     4'hF,    0,    0,  0,    4'h0,    0,  4095, 0, 0, 0};
    vecs[9]  = '{-4096, 0,     0,     0,     4'hF,    0,    0,  0,    4'h0,    0,  -4096,0, 0, 0};
    vecs[10] = '{-4000, 0,     0,     0,     4'hF,    -97,  0,  0,    4'h0,    0,  -4096,1, 1, 1};
    vecs[11] = '{16383, 16383, 16383, 16383, 4'hF,    4095, 0,  0,    4'h0,    0,  4095, 1, 1, 2};
    vecs[12] = '{-16384,-16384,-16384,-16384,4'hF,    -4096,0,  0,    4'h0,    0,  -4096,1, 1, 3};
    vecs[13] = '{4000,  96,    0,     0,     4'hF,    0,    0,  0,    4'h0,    0,  4095, 1, 1, 4};

    bus.store_strb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // Clear and saturated load land on the same edge: count restarts at 1, sticky stays set.
    driveChannels(4000, 4000, 4000, 4000);
    bus.ch_en = 4'hF; bus.banana_corr = '0; bus.const_dac_en = 1'b0; bus.ch_oflow = '0;
    bus.out_cond = 1'b1;
    @(posedge clk); #1;
    bus.out_cond = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.oflow_clr = 1'b1;
    @(posedge clk); #1;
    bus.oflow_clr = 1'b0;
    checkOutput("clrset_valid", int'(bus.fb_valid), 1);
    checkOutput("clrset_fb", int'(bus.fb_sgnl), 4095);
    checkOutput("clrset_sticky", int'(bus.oflow_sticky), 1);
    checkOutput("clrset_count", int'(bus.sat_count), 1);
    repeat (3) @(posedge clk);
    #1;

    // Three back-to-back out_cond pulses give three consecutive loads.
    driveChannels(1, 0, 0, 0);
    bus.out_cond = 1'b1;
    @(posedge clk); #1;
    driveChannels(2, 0, 0, 0);
    @(posedge clk); #1;
    driveChannels(3, 0, 0, 0);
    @(posedge clk); #1;
    bus.out_cond = 1'b0;
    nv = 0; first = -1;
    vals[0] = 0; vals[1] = 0; vals[2] = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus.fb_valid) begin
        if (first < 0) first = k;
        if (nv < 3) vals[nv] = int'(bus.fb_sgnl);
        nv++;
      end
    end
    checkOutput("thru_nvalid", nv, 3);
    checkOutput("thru_first", first, 3);
    checkOutput("thru_val0", vals[0], 1);
    checkOutput("thru_val1", vals[1], 2);
    checkOutput("thru_val2", vals[2], 3);

    v_load = '{1000, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 1000, 0, 1, 1};
    applyStimulus(v_load, 20);
    bus.slew_max   = 8'd100;
    bus.store_strb = 1'b0;
`ifdef FB_SLEW_LIMIT_EN
    @(posedge clk); #1;
    checkOutput("ramp_start", int'(bus.fb_sgnl), 1000);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("ramp_step%0d", i), int'(bus.fb_sgnl), 1000 - 100 * i);
    end
    @(posedge clk); #1;
    checkOutput("ramp_end", int'(bus.fb_sgnl), 0);
`else
    @(posedge clk); #1;
    checkOutput("drop_zero", int'(bus.fb_sgnl), 0);
`endif

    // out_cond with the store window closed must be dropped.
    bus.out_cond = 1'b1;
    @(posedge clk); #1;
    bus.out_cond = 1'b0;
    nv = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus.fb_valid) nv++;
    end
    checkOutput("idle_discard", nv, 0);
    checkOutput("idle_fb", int'(bus.fb_sgnl), 0);

    // Reset two cycles after out_cond flushes the pending load.
    bus.store_strb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    driveChannels(4000, 4000, 4000, 4000);
    bus.out_cond = 1'b1;
    @(posedge clk); #1;
    bus.out_cond = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nv = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.fb_valid) nv++;
    end
    checkOutput("rstflush_nvalid", nv, 0);
    checkOutput("rstflush_fb", int'(bus.fb_sgnl), 0);
    checkOutput("rstflush_oflow", int'(bus.oflow), 0);
    checkOutput("rstflush_sticky", int'(bus.oflow_sticky), 0);
    checkOutput("rstflush_count", int'(bus.sat_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
